// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the Cirno core.
// Walks each instruction through IF/DC/CLS/OF/ALU/RM/WM/RS by instruction class,
// emits one-cycle Moore strobes, counts retired instructions and stops in HALT.
module exec_sequencer #(
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic [2:0]       inst_type,
  input  logic             halt,
  output logic             fetch_unit_en,
  output logic             decoder_en,
  output logic             reg_r_en,
  output logic             alu_en,
  output logic             memory_r_en,
  output logic             memory_w_en,
  output logic             reg_w_en,
  output logic             reg_mem_w_en,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_IF   = 4'd1;
  localparam logic [3:0] S_DC   = 4'd2;
  localparam logic [3:0] S_CLS  = 4'd3;
  localparam logic [3:0] S_OF   = 4'd4;
  localparam logic [3:0] S_ALU  = 4'd5;
  localparam logic [3:0] S_RM   = 4'd6;
  localparam logic [3:0] S_WM   = 4'd7;
  localparam logic [3:0] S_RS   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [2:0] T_ALU  = 3'd1;
  localparam logic [2:0] T_MOV  = 3'd3;
  localparam logic [2:0] T_JMP  = 3'd4;
  localparam logic [2:0] T_ST   = 3'd5;
  localparam logic [2:0] T_LD   = 3'd6;

  // Counter reload value: RM is held MEM_RD_LAT cycles, leaving when the count hits 0.
  localparam logic [2:0] RM_LOAD = 3'(MEM_RD_LAT - 1);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [2:0] typ;
  logic [2:0] rm_cnt;
  logic       retire;
  logic       cls_illegal;

  // Illegal classes 0 and 7 are flagged only when actually executed (not halted).
  assign cls_illegal = (state == S_CLS) && !halt &&
                       ((inst_type == 3'd0) || (inst_type == 3'd7));

  // IF is only reached from IDLE or from the last state of an instruction.
  assign retire = (state_nxt == S_IF) && (state != S_IDLE);

  // Next-state decode; after CLS only the latched class steers the sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_IF;
      S_IF:   state_nxt = S_DC;
      S_DC:   state_nxt = S_CLS;
      S_CLS: begin
        if (halt) begin
          state_nxt = S_HALT;
        end else begin
          case (inst_type)
            T_ALU, T_JMP, T_ST, T_LD: state_nxt = S_OF;
            T_MOV:                    state_nxt = S_RS;
            default:                  state_nxt = S_IF;
          endcase
        end
      end
      S_OF: begin
        case (typ)
          T_ALU:   state_nxt = S_ALU;
          T_ST:    state_nxt = S_WM;
          T_LD:    state_nxt = S_RM;
          default: state_nxt = S_IF;
        endcase
      end
      S_ALU:  state_nxt = S_RS;
      S_RM:   if (rm_cnt == 3'd0) state_nxt = S_RS;
      S_WM:   state_nxt = S_IF;
      S_RS:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Latch the decoder class in CLS so later input changes cannot alter the walk.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)              typ <= 3'd0;
    else if (state == S_CLS)  typ <= inst_type;
  end

  // RM wait counter: load on entry from OF, count down while in RM.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)                                     rm_cnt <= 3'd0;
    else if ((state == S_OF) && (state_nxt == S_RM)) rm_cnt <= RM_LOAD;
    else if ((state == S_RM) && (rm_cnt != 3'd0))    rm_cnt <= rm_cnt - 3'd1;
  end

  // Sticky illegal-class flag.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)          illegal <= 1'b0;
    else if (cls_illegal) illegal <= 1'b1;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)     retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

  // Moore strobes: pure decode of registered state (RS split by latched class).
  assign fetch_unit_en = (state == S_IF);
  assign decoder_en    = (state == S_DC);
  assign reg_r_en      = (state == S_OF);
  assign alu_en        = (state == S_ALU);
  assign memory_r_en   = (state == S_RM);
  assign memory_w_en   = (state == S_WM);
  assign reg_w_en      = (state == S_RS) && (typ != T_LD);
  assign reg_mem_w_en  = (state == S_RS) && (typ == T_LD);
  assign busy          = (state != S_IDLE) && (state != S_HALT);
  assign done          = (state == S_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: directed per-class table, cycle-exact reference
// sequences built from instruction-class rules, resets mid-instruction, halt and wrap.
module tb_exec_sequencer;

  localparam int LAT = 3;
  localparam int CW  = 4;

  localparam logic [7:0] P_F   = 8'h80;
  localparam logic [7:0] P_D   = 8'h40;
  localparam logic [7:0] P_R   = 8'h20;
  localparam logic [7:0] P_A   = 8'h10;
  localparam logic [7:0] P_MR  = 8'h08;
  localparam logic [7:0] P_MW  = 8'h04;
  localparam logic [7:0] P_W   = 8'h02;
  localparam logic [7:0] P_MMW = 8'h01;

  logic          clk = 1'b0;
  logic          init_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    inst_type = 3'd0;
  logic          halt = 1'b0;
  logic          fetch_unit_en, decoder_en, reg_r_en, alu_en;
  logic          memory_r_en, memory_w_en, reg_w_en, reg_mem_w_en;
  logic          busy, done, illegal;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  exec_sequencer #(.MEM_RD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .init_n(init_n), .start(start), .inst_type(inst_type), .halt(halt),
    .fetch_unit_en(fetch_unit_en), .decoder_en(decoder_en), .reg_r_en(reg_r_en),
    .alu_en(alu_en), .memory_r_en(memory_r_en), .memory_w_en(memory_w_en),
    .reg_w_en(reg_w_en), .reg_mem_w_en(reg_mem_w_en), .busy(busy), .done(done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [7:0] stb;
  assign stb = {fetch_unit_en, decoder_en, reg_r_en, alu_en,
                memory_r_en, memory_w_en, reg_w_en, reg_mem_w_en};

  // One expected cycle plus the inputs to drive for the following edge.
  typedef struct {
    logic [7:0] stb;
    logic       busy;
    logic       done;
    logic       ill;
    logic [3:0] ret;
    logic       cls;
    logic [2:0] typ;
    logic       hlt;
    logic       st;
  } rec_t;

  rec_t exp_q[$];
  int   prog[$];

  // Directed table: one instruction of each class, measured IF-to-IF.
  typedef struct {
    int typ;
    int period;
    int memr;
    int memw;
    int regw;
    int regmemw;
    int ill;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic add(input logic [7:0] s, input logic b, input logic d, input logic il,
                     input logic [3:0] rt, input logic c, input logic [2:0] ty,
                     input logic h, input logic sv);
    rec_t r;
    r.stb = s; r.busy = b; r.done = d; r.ill = il; r.ret = rt;
    r.cls = c; r.typ = ty; r.hlt = h; r.st = sv;
    exp_q.push_back(r);
  endtask

  // Expand the program into the expected per-cycle trace.
  task automatic build(input int n_idle, input bit with_halt, input int n_halt);
    logic [3:0] ret;
    logic       ill;
    int         t;
    ret = 4'd0;
    ill = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n_idle; i++)
      add(8'h00, 1'b0, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, (i == n_idle - 1));
    foreach (prog[k]) begin
      t = prog[k];
      add(P_F, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
      add(P_D, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
      add(8'h00, 1'b1, 1'b0, ill, ret, 1'b1, 3'(t), 1'b0, 1'($urandom));
      if (t == 0 || t == 7) ill = 1'b1;
      case (t)
        1: begin
          add(P_R, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
          add(P_A, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
          add(P_W, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
        end
        3: add(P_W, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
        4: add(P_R, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
        5: begin
          add(P_R, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
          add(P_MW, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
        end
        6: begin
          add(P_R, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
          for (int j = 0; j < LAT; j++)
            add(P_MR, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
          add(P_MMW, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
        end
        default: ;
      endcase
      ret = ret + 4'd1;
    end
    if (with_halt) begin
      add(P_F, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
      add(P_D, 1'b1, 1'b0, ill, ret, 1'b0, 3'd0, 1'b0, 1'($urandom));
      add(8'h00, 1'b1, 1'b0, ill, ret, 1'b1, 3'($urandom_range(1, 6)), 1'b1, 1'b1);
      for (int i = 0; i < n_halt; i++)
        add(8'h00, 1'b0, 1'b1, ill, ret, 1'b0, 3'd0, 1'b0, 1'b1);
    end
  endtask

  // Apply the trace: compare at each negedge, then drive inputs for the next edge.
  task automatic run(input int limit);
    int   n;
    rec_t r;
    n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      r = exp_q[i];
      checks++;
      if ({stb, busy, done, illegal, retired} !== {r.stb, r.busy, r.done, r.ill, r.ret}) begin
        errors++;
        $display("FAIL seq[%0d]: got stb=%b busy=%b done=%b ill=%b ret=%0d want stb=%b busy=%b done=%b ill=%b ret=%0d",
                 i, stb, busy, done, illegal, retired, r.stb, r.busy, r.done, r.ill, r.ret);
      end
      start = r.st;
      if (r.cls) begin
        inst_type = r.typ;
        halt      = r.hlt;
      end else begin
        inst_type = 3'($urandom);
        halt      = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  // Assert reset at the current negedge, check outputs, release on the next negedge.
  task automatic do_reset();
    init_n = 1'b0;
    start  = 1'b0;
    #1;
    checks++;
    if ({stb, busy, done, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset: got stb=%b busy=%b done=%b ill=%b ret=%0d want all 0",
               stb, busy, done, illegal, retired);
    end
    @(negedge clk);
    init_n = 1'b1;
  endtask

  task automatic measure(input vec_t e);
    int  cyc, period, memr, memw, rw, rmw;
    bit  seen, fin;
    do_reset();
    start = 1'b1;
    inst_type = 3'(e.typ);
    halt = 1'b0;
    cyc = 0; period = 0; memr = 0; memw = 0; rw = 0; rmw = 0;
    seen = 0; fin = 0;
    while (cyc < 40 && !fin) begin
      @(negedge clk);
      cyc++;
      if (fetch_unit_en) begin
        if (seen) fin = 1;
        else seen = 1;
      end
      if (seen && !fin) begin
        period++;
        memr += int'(memory_r_en);
        memw += int'(memory_w_en);
        rw   += int'(reg_w_en);
        rmw  += int'(reg_mem_w_en);
      end
    end
    chk($sformatf("t%0d refetch", e.typ), int'(fin), 1);
    chk($sformatf("t%0d period", e.typ), period, e.period);
    chk($sformatf("t%0d memr", e.typ), memr, e.memr);
    chk($sformatf("t%0d memw", e.typ), memw, e.memw);
    chk($sformatf("t%0d regw", e.typ), rw, e.regw);
    chk($sformatf("t%0d regmemw", e.typ), rmw, e.regmemw);
    chk($sformatf("t%0d illegal", e.typ), int'(illegal), e.ill);
    chk($sformatf("t%0d retired", e.typ), int'(retired), 1);
  endtask

  initial begin
    //           typ period memr memw regw regmemw ill
    vt[0] = '{0, 3, 0, 0, 0, 0, 1};
    vt[1] = '{1, 6, 0, 0, 1, 0, 0};
    vt[2] = '{2, 3, 0, 0, 0, 0, 0};
    vt[3] = '{3, 4, 0, 0, 1, 0, 0};
    vt[4] = '{4, 4, 0, 0, 0, 0, 0};
    vt[5] = '{5, 5, 0, 1, 0, 0, 0};
    vt[6] = '{6, 5 + LAT, LAT, 0, 0, 1, 0};
    vt[7] = '{7, 3, 0, 0, 0, 0, 1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) measure(vt[i]);

    // Reset mid-ALU after an illegal instruction has set the sticky flag.
    do_reset();
    prog = '{7, 1};
    build(2, 1'b0, 0);
    run(2 + 3 + 4);
    chk("mid_alu alu_en", int'(alu_en), 1);
    chk("mid_alu illegal", int'(illegal), 1);
    do_reset();

    // Reset while RM is waiting; the following load must see a full wait again.
    prog = '{6, 6};
    build(1, 1'b0, 0);
    run(1 + 5);
    chk("mid_rm memr", int'(memory_r_en), 1);
    do_reset();
    prog = '{6};
    build(1, 1'b1, 3);
    run(-1);

    // Mixed classes back to back.
    do_reset();
    prog = '{2, 3, 4, 5};
    build(2, 1'b1, 2);
    run(-1);
    chk("mix retired", int'(retired), 4);

    // Illegal class stays flagged over later legal instructions.
    do_reset();
    prog = '{7};
    for (int i = 0; i < 10; i++) prog.push_back(int'($urandom_range(1, 6)));
    build(1, 1'b1, 2);
    run(-1);
    chk("sticky illegal", int'(illegal), 1);

    // Halt after five instructions; start held high while halted.
    do_reset();
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(int'($urandom_range(1, 6)));
    build(3, 1'b1, 20);
    run(-1);
    chk("halt done", int'(done), 1);
    chk("halt busy", int'(busy), 0);
    chk("halt retired", int'(retired), 5);

    // Seventeen instructions wrap a 4-bit counter to 1.
    do_reset();
    prog.delete();
    for (int i = 0; i < 17; i++) prog.push_back(int'($urandom_range(1, 6)));
    build(1, 1'b1, 2);
    run(-1);
    chk("wrap retired", int'(retired), 1);

    // Random programs over all classes.
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      prog.delete();
      for (int i = 0; i < int'($urandom_range(15, 25)); i++)
        prog.push_back(int'($urandom_range(0, 7)));
      build(int'($urandom_range(1, 4)), 1'b1, 6);
      run(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
